// File: rtl/usb_transmitter_if.sv
// Bus bundle for the full-speed USB transmitter: start/length handshake,
// packet buffer read port and the D+/D- drive signals.
interface usb_transmitter_if #(
  parameter int BUFFER_SIZE = 1024
);
  localparam int LW = $clog2(BUFFER_SIZE) + 1;
  localparam int AW = $clog2(BUFFER_SIZE / 4);

  logic          tx_start;
  logic [LW-1:0] tx_length;
  logic          tx_busy;
  logic          tx_done;
  logic [AW-1:0] buffer_address;
  logic [31:0]   buffer_read_value;
  logic          usb_tx_oe;
  logic          usb_tx_dp;
  logic          usb_tx_dn;

  // The transmitter itself is the master side.
  modport master (
    input  tx_start, tx_length, buffer_read_value,
    output tx_busy, tx_done, buffer_address, usb_tx_oe, usb_tx_dp, usb_tx_dn
  );

  modport slave (
    output tx_start, tx_length, buffer_read_value,
    input  tx_busy, tx_done, buffer_address, usb_tx_oe, usb_tx_dp, usb_tx_dn
  );
endinterface

// File: rtl/usb_transmitter.sv
// Full-speed USB packet transmitter: SYNC, NRZI, bit stuffing and EOP on D+/D-,
// reading the packet bytes from a registered word-wide buffer port.
module usb_transmitter #(
  parameter int BUFFER_SIZE    = 1024,
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic              clk48,
  input  logic              rst_n,
  usb_transmitter_if.master bus
);
  localparam int LW = $clog2(BUFFER_SIZE) + 1;
  localparam int AW = $clog2(BUFFER_SIZE / 4);
  localparam logic [1:0] LAST_PHASE = 2'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        r_state, w_stateNext;
  logic [1:0]    r_phase, w_phaseNext;
  logic [2:0]    r_bitCnt, w_bitCntNext;
  logic [LW-1:0] r_byteCnt, w_byteCntNext;
  logic [LW-1:0] r_length, w_lengthNext;
  logic [2:0]    r_ones, w_onesNext;
  logic [31:0]   r_word, w_wordNext;
  logic [AW-1:0] r_addr, w_addrNext;
  logic          r_dp, w_dpNext;
  logic          r_dn, w_dnNext;
  logic          r_oe, w_oeNext;
  logic          r_busy, w_busyNext;
  logic          r_done, w_doneNext;

  logic          w_bitLast;
  logic          w_accept;
  logic          w_emit;
  logic          w_bitVal;
  logic          w_startByte;
  logic [4:0]    w_idx;
  logic [2:0]    w_bitInc;
  logic [LW-1:0] w_byteInc;

  assign w_bitLast = (r_phase == LAST_PHASE);
  assign w_bitInc  = r_bitCnt + 3'd1;
  assign w_byteInc = r_byteCnt + LW'(1);
  assign w_accept  = bus.tx_start && !r_busy && (bus.tx_length != '0) &&
                     (bus.tx_length <= LW'(BUFFER_SIZE));

  // Line outputs are registered; each bit boundary decides the next bit to
  // drive: a stuffed toggle when six ones have gone out, otherwise the next
  // SYNC/data bit. Stuffing never advances the bit/byte pointers.
  always_comb begin
    w_stateNext   = r_state;
    w_phaseNext   = w_bitLast ? 2'd0 : r_phase + 2'd1;
    w_bitCntNext  = r_bitCnt;
    w_byteCntNext = r_byteCnt;
    w_lengthNext  = r_length;
    w_onesNext    = r_ones;
    w_wordNext    = r_word;
    w_addrNext    = r_addr;
    w_dpNext      = r_dp;
    w_dnNext      = r_dn;
    w_oeNext      = r_oe;
    w_busyNext    = r_busy;
    w_doneNext    = 1'b0;
    w_emit        = 1'b0;
    w_bitVal      = 1'b0;
    w_startByte   = 1'b0;
    w_idx         = '0;

    case (r_state)
      IDLE: begin
        w_dpNext = 1'b1;
        w_dnNext = 1'b0;
        w_oeNext = 1'b0;
        if (w_accept) begin
          // First SYNC bit is a 0, so the line starts at K right away.
          w_stateNext   = SYNC;
          w_phaseNext   = 2'd0;
          w_lengthNext  = bus.tx_length;
          w_addrNext    = '0;
          w_bitCntNext  = 3'd0;
          w_byteCntNext = '0;
          w_onesNext    = 3'd0;
          w_dpNext      = 1'b0;
          w_dnNext      = 1'b1;
          w_oeNext      = 1'b1;
          w_busyNext    = 1'b1;
        end
      end
      SYNC, DATA: begin
        if (w_bitLast) begin
          if (r_ones == 3'd6) begin
            w_dpNext   = r_dn;
            w_dnNext   = r_dp;
            w_onesNext = 3'd0;
          end else if (r_state == SYNC) begin
            w_emit = 1'b1;
            if (r_bitCnt != 3'd7) begin
              w_bitCntNext = w_bitInc;
              w_bitVal     = (r_bitCnt == 3'd6);
            end else begin
              w_stateNext   = DATA;
              w_bitCntNext  = 3'd0;
              w_byteCntNext = '0;
              w_wordNext    = bus.buffer_read_value;
              w_bitVal      = bus.buffer_read_value[0];
              w_startByte   = 1'b1;
            end
          end else if (r_bitCnt != 3'd7) begin
            w_emit       = 1'b1;
            w_bitCntNext = w_bitInc;
            w_idx        = {r_byteCnt[1:0], w_bitInc};
            w_bitVal     = r_word[w_idx];
          end else if (w_byteInc < r_length) begin
            w_emit        = 1'b1;
            w_byteCntNext = w_byteInc;
            w_bitCntNext  = 3'd0;
            w_startByte   = 1'b1;
            if (w_byteInc[1:0] == 2'd0) begin
              w_wordNext = bus.buffer_read_value;
              w_bitVal   = bus.buffer_read_value[0];
            end else begin
              w_idx    = {w_byteInc[1:0], 3'd0};
              w_bitVal = r_word[w_idx];
            end
          end else begin
            w_stateNext  = EOP_SE0;
            w_bitCntNext = 3'd0;
            w_dpNext     = 1'b0;
            w_dnNext     = 1'b0;
          end
        end
      end
      EOP_SE0: begin
        if (w_bitLast) begin
          if (r_bitCnt == 3'd0) begin
            w_bitCntNext = 3'd1;
          end else begin
            w_stateNext = EOP_J;
            w_dpNext    = 1'b1;
            w_dnNext    = 1'b0;
          end
        end
      end
      EOP_J: begin
        if (w_bitLast) begin
          w_stateNext = IDLE;
          w_oeNext    = 1'b0;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase

    // NRZI: a 1 holds the line, a 0 toggles it and clears the run of ones.
    if (w_emit) begin
      if (w_bitVal) begin
        w_onesNext = (r_ones == 3'd6) ? 3'd6 : r_ones + 3'd1;
      end else begin
        w_dpNext   = r_dn;
        w_dnNext   = r_dp;
        w_onesNext = 3'd0;
      end
    end

    // Request the following word a full word ahead, only if it holds packet bytes.
    if (w_startByte && (w_byteCntNext[1:0] == 2'd0) &&
        ((w_byteCntNext + LW'(4)) < r_length)) begin
      w_addrNext = r_addr + AW'(1);
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_phase   <= 2'd0;
      r_bitCnt  <= 3'd0;
      r_byteCnt <= '0;
      r_length  <= '0;
      r_ones    <= 3'd0;
      r_word    <= '0;
      r_addr    <= '0;
      r_dp      <= 1'b1;
      r_dn      <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_phase   <= w_phaseNext;
      r_bitCnt  <= w_bitCntNext;
      r_byteCnt <= w_byteCntNext;
      r_length  <= w_lengthNext;
      r_ones    <= w_onesNext;
      r_word    <= w_wordNext;
      r_addr    <= w_addrNext;
      r_dp      <= w_dpNext;
      r_dn      <= w_dnNext;
      r_oe      <= w_oeNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  assign bus.tx_busy        = r_busy;
  assign bus.tx_done        = r_done;
  assign bus.buffer_address = r_addr;
  assign bus.usb_tx_oe      = r_oe;
  assign bus.usb_tx_dp      = r_dp;
  assign bus.usb_tx_dn      = r_dn;
endmodule

// File: tb/tb_usb_transmitter.sv
// Randomized scoreboard bench for usb_transmitter: a line-level reference model
// fills the expectation queues, a negedge monitor checks and decodes each packet.
module tb_usb_transmitter;
  localparam int BUFFER_SIZE = 1024;
  localparam int CPB         = 4;
  localparam int LW          = $clog2(BUFFER_SIZE) + 1;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk48 = 1'b0;
  logic rst_n;
  always #5 clk48 = ~clk48;

  usb_transmitter_if #(.BUFFER_SIZE(BUFFER_SIZE)) bus();

  usb_transmitter #(.BUFFER_SIZE(BUFFER_SIZE), .CLOCKS_PER_BIT(CPB)) dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [31:0] mem [256];
  always @(posedge clk48) bus.buffer_read_value <= mem[bus.buffer_address];

  int compared   = 0;
  int mismatched = 0;

  int         expNb[$];
  int         expLen[$];
  logic [1:0] expSyms[$];
  logic [7:0] expBytes[$];
  logic [7:0] pktBytes[$];

  // Reference model: bit list -> stuffing -> NRZI line symbols -> EOP.
  function automatic int buildExpected();
    int         bits[$];
    logic [1:0] line = J;
    int         ones = 0;
    int         nb   = 0;
    for (int i = 0; i < 7; i++) bits.push_back(0);
    bits.push_back(1);
    foreach (pktBytes[b])
      for (int k = 0; k < 8; k++) bits.push_back(int'((pktBytes[b] >> k) & 8'h01));
    foreach (bits[i]) begin
      if (bits[i] == 0) begin
        line = (line == J) ? K : J;
        ones = 0;
      end else begin
        ones++;
      end
      expSyms.push_back(line);
      nb++;
      if (ones == 6) begin
        line = (line == J) ? K : J;
        expSyms.push_back(line);
        nb++;
        ones = 0;
      end
    end
    expSyms.push_back(SE0);
    expSyms.push_back(SE0);
    expSyms.push_back(J);
    nb += 3;
    expNb.push_back(nb);
    expLen.push_back(pktBytes.size());
    foreach (pktBytes[b]) expBytes.push_back(pktBytes[b]);
    return nb;
  endfunction

  task automatic pulseStart(input int len);
    @(negedge clk48);
    bus.tx_length = LW'(len);
    bus.tx_start  = 1'b1;
    @(negedge clk48);
    bus.tx_start  = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input bit expectAccept, output int nb);
    nb = 0;
    if (expectAccept) begin
      for (int i = 0; i < len; i++) mem[i / 4][8 * (i % 4) +: 8] = pktBytes[i];
      nb = buildExpected();
    end
    pulseStart(len);
  endtask

  task automatic waitDone(input int nb);
    bit seen = 1'b0;
    for (int c = 0; c < nb * CPB + 40 && !seen; c++) begin
      @(negedge clk48);
      if (bus.tx_done) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL doneTimeout: got no tx_done, want pulse within %0d cycles", nb * CPB + 40);
    end
    repeat (3) @(negedge clk48);
  endtask

  task automatic sendPacket(input int len);
    int nb;
    applyStimulus(len, 1'b1, nb);
    waitDone(nb);
  endtask

  // Monitor state
  logic [2:0] samples[$];
  logic [1:0] curSyms[$];
  logic [7:0] curBytes[$];
  int curNb, curLen, maxAddr;
  bit inPkt = 1'b0, prevBusy = 1'b0;

  task automatic checkOutput();
    bit         ok;
    logic [1:0] prev = J;
    logic [1:0] s;
    int         ones = 0;
    int         bitsQ[$];
    logic [7:0] byteVal;

    compared++;
    if (samples.size() != curNb * CPB) begin
      mismatched++;
      $display("[TB] FAIL busyLen: got %0d cycles, want %0d", samples.size(), curNb * CPB);
    end
    for (int i = 0; i < curNb; i++) begin
      ok = 1'b1;
      for (int p = 0; p < CPB; p++)
        if (i * CPB + p >= samples.size() || samples[i * CPB + p] != {1'b1, curSyms[i]}) ok = 1'b0;
      compared++;
      if (!ok) begin
        mismatched++;
        $display("[TB] FAIL bit%0d: got oe/dp/dn %b, want %b held %0d cycles", i,
                 (i * CPB < samples.size()) ? samples[i * CPB] : 3'bxxx, {1'b1, curSyms[i]}, CPB);
      end
    end
    compared++;
    if (bus.tx_done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL donePulse: got %b, want 1", bus.tx_done);
    end
    compared++;
    if (maxAddr != (curLen - 1) / 4) begin
      mismatched++;
      $display("[TB] FAIL maxAddr: got %0d, want %0d", maxAddr, (curLen - 1) / 4);
    end
    // Independent decode: NRZI back to bits, drop stuffed bits and SYNC.
    for (int i = 0; i * CPB + 1 < samples.size(); i++) begin
      s = samples[i * CPB + 1][1:0];
      if (s == SE0) break;
      if (ones == 6) begin
        ones = 0;
      end else begin
        bitsQ.push_back((s == prev) ? 1 : 0);
        ones = (s == prev) ? ones + 1 : 0;
      end
      prev = s;
    end
    ok = (bitsQ.size() == 8 + 8 * curLen);
    for (int k = 0; ok && k < curLen; k++) begin
      for (int b = 0; b < 8; b++) byteVal[b] = bitsQ[8 + 8 * k + b][0];
      if (byteVal != curBytes[k]) ok = 1'b0;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL decode: got %0d bits, want %0d bits matching %0d bytes", bitsQ.size(), 8 + 8 * curLen, curLen);
    end
  endtask

  // Pops an expectation when busy rises, collects line samples, judges at busy fall.
  always @(negedge clk48) begin
    if (!rst_n) begin
      inPkt    = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (bus.tx_busy && !prevBusy) begin
        compared++;
        if (expNb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpectedStart: got busy=1, want busy=0");
          inPkt = 1'b0;
        end else begin
          curNb  = expNb.pop_front();
          curLen = expLen.pop_front();
          curSyms.delete();
          curBytes.delete();
          for (int i = 0; i < curNb; i++) curSyms.push_back(expSyms.pop_front());
          for (int i = 0; i < curLen; i++) curBytes.push_back(expBytes.pop_front());
          samples.delete();
          maxAddr = 0;
          inPkt   = 1'b1;
        end
      end
      if (inPkt && bus.tx_busy) begin
        samples.push_back({bus.usb_tx_oe, bus.usb_tx_dp, bus.usb_tx_dn});
        if (int'(bus.buffer_address) > maxAddr) maxAddr = int'(bus.buffer_address);
      end
      if (!bus.tx_busy && prevBusy && inPkt) begin
        checkOutput();
        inPkt = 1'b0;
      end else if (!bus.tx_busy) begin
        compared++;
        if (bus.usb_tx_oe || !bus.usb_tx_dp || bus.usb_tx_dn || bus.tx_done) begin
          mismatched++;
          $display("[TB] FAIL idle: got oe/dp/dn/done %b%b%b%b, want 0100",
                   bus.usb_tx_oe, bus.usb_tx_dp, bus.usb_tx_dn, bus.tx_done);
        end
      end
      prevBusy = bus.tx_busy;
    end
  end

  initial begin
    #3_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nb;
    int len;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n         = 1'b0;
    bus.tx_start  = 1'b0;
    bus.tx_length = '0;
    #23;
    compared++;
    if (bus.usb_tx_oe !== 1'b0 || bus.usb_tx_dp !== 1'b1 || bus.usb_tx_dn !== 1'b0 ||
        bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0 || bus.buffer_address !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset: got oe/dp/dn/busy/done %b%b%b%b%b addr %0d, want 01000 addr 0",
               bus.usb_tx_oe, bus.usb_tx_dp, bus.usb_tx_dn, bus.tx_busy, bus.tx_done, bus.buffer_address);
    end
    @(negedge clk48);
    rst_n = 1'b1;
    repeat (4) @(negedge clk48);

    pktBytes = '{8'hD2};
    sendPacket(1);
    pktBytes = '{8'hFF};
    sendPacket(1);
    pktBytes = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04};
    sendPacket(5);
    pktBytes = '{8'h7F, 8'hFE, 8'h3F};
    sendPacket(3);

    applyStimulus(0, 1'b0, nb);
    repeat (10) @(negedge clk48);
    applyStimulus(1025, 1'b0, nb);
    repeat (10) @(negedge clk48);

    pktBytes = '{8'hA5, 8'h5A};
    applyStimulus(2, 1'b1, nb);
    repeat (10) @(negedge clk48);
    pulseStart(1);
    waitDone(nb);

    // Start request landing on the final EOP_J edge must be ignored.
    pktBytes = '{8'h00};
    applyStimulus(1, 1'b1, nb);
    repeat (nb * CPB - 1) @(negedge clk48);
    bus.tx_length = LW'(1);
    bus.tx_start  = 1'b1;
    @(negedge clk48);
    bus.tx_start  = 1'b0;
    repeat (12) @(negedge clk48);

    pktBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(5, 1'b1, nb);
    repeat (20 * CPB) @(negedge clk48);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (bus.usb_tx_oe !== 1'b0 || bus.usb_tx_dp !== 1'b1 || bus.usb_tx_dn !== 1'b0 ||
        bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort: got oe/dp/dn/busy/done %b%b%b%b%b, want 01000",
               bus.usb_tx_oe, bus.usb_tx_dp, bus.usb_tx_dn, bus.tx_busy, bus.tx_done);
    end
    repeat (2) @(negedge clk48);
    rst_n = 1'b1;
    repeat (20) @(negedge clk48);

    for (int n = 0; n < 20; n++) begin
      len = (n == 19) ? int'($urandom_range(60, 100)) : int'($urandom_range(1, 24));
      pktBytes.delete();
      for (int i = 0; i < len; i++)
        pktBytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      sendPacket(len);
    end

    repeat (10) @(negedge clk48);
    compared++;
    if (expNb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL leftover: got %0d pending packets, want 0", expNb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
